key_tx_sequencer: RTL and testbench
===================================

Name: key_tx_sequencer

Overview:
Sequences the 256-bit decrypted key out over the UART transmitter one byte at a time, gated by the PIN-unlock condition. Sits between the AES key output, the PIN/ROM unlock logic and the Transmitter. Replaces free-running byte selection with a handshake-driven scheduler: one byte per Transmitter frame, inter-byte gap, abort on lock loss, and key wipe after use.

Parameters:
NUM_BYTES, 32, key bytes per stream; key width = NUM_BYTES*8.
GAP_CLKS, 87, idle clocks between Transmitter done and the next tx_dv_o pulse; 0 is legal, giving no gap.
TIMEOUT_CLKS, 2048, maximum clocks from tx_dv_o to tx_done_i before the stream aborts.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle request to stream the key
unlock_i  in  1  level, high while the PIN is validated
key_i  in  NUM_BYTES*8  decrypted key; byte k = key_i[k*8+:8]
tx_active_i  in  1  Transmitter busy
tx_done_i  in  1  Transmitter one-cycle frame-complete pulse
tx_dv_o  out  1  one-cycle byte-valid pulse to the Transmitter
tx_byte_o  out  8  byte to send; held stable from tx_dv_o until tx_done_i
byte_idx_o  out  5  index of the byte currently in flight
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse after a complete stream
abort_o  out  1  one-cycle pulse when a stream ends early

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; key shadow register, counters and byte index cleared.
- IDLE: on start_i=1 with unlock_i=1 and tx_active_i=0, go to LOAD. Otherwise start_i is ignored and produces no abort_o.
- LOAD (1 cycle): copy key_i into the shadow register; idx=0; go to SEND. Later changes on key_i do not affect a stream in progress.
- SEND (1 cycle): drive tx_byte_o=shadow[idx*8+:8] and tx_dv_o=1; clear the timeout counter; go to WAIT. First tx_dv_o is 2 cycles after start_i.
- WAIT: tx_byte_o held. On tx_done_i: if idx==NUM_BYTES-1 go to FINISH, else idx++ and go to GAP. If the timeout counter reaches TIMEOUT_CLKS-1, go to ABORT.
- GAP: count GAP_CLKS cycles, then go to SEND. With GAP_CLKS=0, go to SEND on the next cycle.
- FINISH (1 cycle): done_o=1; wipe the shadow register; go to IDLE.
- ABORT (1 cycle): abort_o=1; wipe the shadow register; go to IDLE.
- Lock loss, unlock_i=0 in GAP or SEND: go to ABORT immediately; no further tx_dv_o.
- Lock loss in WAIT: the current frame cannot be cancelled. Wait for tx_done_i or timeout, then go to ABORT, not GAP or FINISH.
- start_i while busy_o=1: ignored.
- tx_done_i outside WAIT: ignored.
- tx_done_i and timeout in the same cycle: tx_done_i wins.
- Wipe means the shadow register is all zeros, and tx_byte_o reads 0 in IDLE.
- The timeout counter saturates and never wraps.

Optional Feature:
CHECKSUM_EN
- Defined: after byte NUM_BYTES-1 completes, one extra frame is sent carrying the XOR of all key bytes, via state CSUM (SEND/WAIT semantics, same gap and timeout rules). byte_idx_o reads NUM_BYTES for this frame. done_o pulses after the checksum frame. Lock loss during the checksum frame aborts as above.
- Undefined: the stream ends after the key bytes; no checksum logic is generated.

Decomposition:
- Package keytx_pkg:
  - state enum (IDLE, LOAD, SEND, WAIT, GAP, CSUM, FINISH, ABORT);
  - KEY_BYTES_DEFAULT=32;
  - byte-index width constant ($clog2(NUM_BYTES+1));
  - byte typedef.
- One sub-module, keytx_timer: a loadable down-counter with a zero flag, instantiated twice (gap counter and timeout counter).

Test Plan:
- Key bytes 0x00..0x1F, unlock=1, start pulse, Transmitter model with done 10 clks after dv, GAP_CLKS=4 -> 32 tx_dv_o pulses carrying 0x00..0x1F in order, consecutive dv pulses 15 clks apart, done_o once, shadow register reads 0.
- unlock_i dropped in WAIT of byte 5 -> byte 5 frame completes, abort_o 1 cycle after tx_done_i, no 7th dv, busy_o=0.
- Model never asserts done, TIMEOUT_CLKS=16 -> abort_o exactly 16 clks after the first dv; start_i accepted again afterwards.
- start_i with unlock_i=0, and start_i while busy -> no dv, no abort_o, stream unchanged.
- rst_i asserted mid-stream (byte 12), asynchronously between clock edges -> all outputs 0 immediately; next start_i restarts at byte 0.
- CHECKSUM_EN defined, key all 0xA5 -> 33rd frame byte=0x00, byte_idx_o=32; with key byte0=0x01 and rest 0 -> checksum byte=0x01.

Source files
------------

// File: rtl/keytx_pkg.sv
// Shared types and sizing helpers for the key transmit sequencer.
// Optional checksum frame is selected by CHECKSUM_EN.
package keytx_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT, GAP, CSUM, FINISH, ABORT
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int KEY_BYTES_DEFAULT = 32;

  // The checksum frame reports index NUM_BYTES, so it needs one more code point.
  function automatic int idx_width(input int n);
`ifdef CHECKSUM_EN
    return $clog2(n + 1);
`else
    return (n > 1) ? $clog2(n) : 1;
`endif
  endfunction

  localparam int KEY_IDX_W = idx_width(KEY_BYTES_DEFAULT);

endpackage

// File: rtl/key_tx_sequencer_if.sv
// Byte handshake between the key sequencer (master) and the UART Transmitter (slave).
interface key_tx_sequencer_if;
  logic              tx_active_i;
  logic              tx_done_i;
  logic              tx_dv_o;
  keytx_pkg::byte_t  tx_byte_o;

  modport master (input tx_active_i, input tx_done_i, output tx_dv_o, output tx_byte_o);
  modport slave  (output tx_active_i, output tx_done_i, input tx_dv_o, input tx_byte_o);
endinterface

// File: rtl/keytx_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags an expired count.
module keytx_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/key_tx_sequencer.sv
// Streams a latched key one byte per Transmitter frame while unlocked; first tx_dv_o 2 clks after start_i.
// Frames are paced by tx_done_i plus GAP_CLKS; lock loss or timeout aborts and wipes. CHECKSUM_EN adds an XOR frame.
module key_tx_sequencer
  import keytx_pkg::*;
#(
  parameter int NUM_BYTES    = KEY_BYTES_DEFAULT,
  parameter int GAP_CLKS     = 87,
  parameter int TIMEOUT_CLKS = 2048,
  localparam int IDX_W       = idx_width(NUM_BYTES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   unlock_i,
  input  logic [NUM_BYTES*8-1:0] key_i,
  key_tx_sequencer_if.master     tx,
  output logic [IDX_W-1:0]       byte_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   abort_o
);

  localparam int SEL_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int TO_W  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // Loaded on the dv cycle so it expires on the (TIMEOUT_CLKS-1)th clock after tx_dv_o.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CLKS - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  state_t                 state_q, state_d;
  logic [NUM_BYTES*8-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   lost_q, lost_d;
  logic                   gap_load, gap_zero, to_load, to_zero;
  logic                   tx_dv;
  byte_t                  tx_byte, key_byte, cur_byte;
  logic                   lost;

  assign key_byte = byte_t'(shadow_q >> {idx_q[SEL_W-1:0], 3'b000});
  assign lost     = lost_q | ~unlock_i;

`ifdef CHECKSUM_EN
  byte_t csum;
  logic  csum_frame;

  always_comb begin
    csum = '0;
    for (int k = 0; k < NUM_BYTES; k++) csum ^= shadow_q[k*8 +: 8];
  end

  assign csum_frame = (idx_q == IDX_W'(NUM_BYTES));
  assign cur_byte   = csum_frame ? csum : key_byte;
`else
  logic last;
  assign last     = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign cur_byte = key_byte;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    lost_d   = lost_q;
    gap_load = 1'b0;
    to_load  = 1'b0;
    tx_dv    = 1'b0;
    tx_byte  = '0;
    done_o   = 1'b0;
    abort_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && unlock_i && !tx.tx_active_i) state_d = LOAD;
      end
      LOAD: begin
        shadow_d = key_i;
        idx_d    = '0;
        lost_d   = 1'b0;
        state_d  = SEND;
      end
      SEND, CSUM: begin
        tx_byte = cur_byte;
        if (!unlock_i) begin
          state_d = ABORT;
        end else begin
          tx_dv   = 1'b1;
          to_load = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The frame already on the wire finishes; lock loss only decides where we go next.
        tx_byte = cur_byte;
        if (!unlock_i) lost_d = 1'b1;
        if (tx.tx_done_i) begin
          if (lost) begin
            state_d = ABORT;
`ifdef CHECKSUM_EN
          end else if (csum_frame) begin
`else
          end else if (last) begin
`endif
            state_d = FINISH;
          end else begin
            idx_d = idx_q + 1'b1;
            if (GAP_CLKS == 0) begin
`ifdef CHECKSUM_EN
              state_d = (idx_d == IDX_W'(NUM_BYTES)) ? CSUM : SEND;
`else
              state_d = SEND;
`endif
            end else begin
              gap_load = 1'b1;
              state_d  = GAP;
            end
          end
        end else if (to_zero) begin
          state_d = ABORT;
        end
      end
      GAP: begin
        if (!unlock_i) begin
          state_d = ABORT;
        end else if (gap_zero) begin
`ifdef CHECKSUM_EN
          state_d = csum_frame ? CSUM : SEND;
`else
          state_d = SEND;
`endif
        end
      end
      FINISH: begin
        done_o   = 1'b1;
        shadow_d = '0;
        idx_d    = '0;
        state_d  = IDLE;
      end
      ABORT: begin
        abort_o  = 1'b1;
        shadow_d = '0;
        idx_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      lost_q   <= lost_d;
    end
  end

  keytx_timer #(.W(GAP_W)) u_gap_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (gap_load),
    .en_i       (state_q == GAP),
    .load_val_i (GAP_LOAD),
    .zero_o     (gap_zero)
  );

  keytx_timer #(.W(TO_W)) u_timeout_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (to_load),
    .en_i       (state_q == WAIT),
    .load_val_i (TO_LOAD),
    .zero_o     (to_zero)
  );

  assign tx.tx_dv_o   = tx_dv;
  assign tx.tx_byte_o = tx_byte;
  assign byte_idx_o   = idx_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_key_tx_sequencer.sv
// Directed bench: Transmitter model answers each frame 10 clks after tx_dv_o; GAP_CLKS=4, TIMEOUT_CLKS=16.
module tb_key_tx_sequencer;
  import keytx_pkg::*;

  localparam int NB = 32;
  localparam int IW = idx_width(NB);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            unlock = 1'b0;
  logic [NB*8-1:0] key = '0;
  logic [IW-1:0]   idx;
  logic            busy, done, abort;

  key_tx_sequencer_if tx_if ();

  key_tx_sequencer #(.NUM_BYTES(NB), .GAP_CLKS(4), .TIMEOUT_CLKS(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .unlock_i   (unlock),
    .key_i      (key),
    .tx         (tx_if),
    .byte_idx_o (idx),
    .busy_o     (busy),
    .done_o     (done),
    .abort_o    (abort)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model and output monitor, all sampled on the falling edge.
  byte_t         dvq_byte[$];
  logic [IW-1:0] dvq_idx[$];
  int            dvq_cyc[$];
  int            done_cnt = 0, abort_cnt = 0, abort_cyc = 0, last_done_cyc = 0;
  bit            done_en = 1'b1;

  initial begin
    int fcnt;
    fcnt = 0;
    tx_if.tx_active_i = 1'b0;
    tx_if.tx_done_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_if.tx_active_i = 1'b0;
        tx_if.tx_done_i   = 1'b0;
        fcnt = 0;
      end else begin
        if (tx_if.tx_done_i) begin
          tx_if.tx_done_i   = 1'b0;
          tx_if.tx_active_i = 1'b0;
        end
        if (fcnt > 0) begin
          fcnt--;
          if (fcnt == 0) begin
            if (done_en) begin
              tx_if.tx_done_i = 1'b1;
              last_done_cyc = cyc;
            end else begin
              tx_if.tx_active_i = 1'b0;
            end
          end
        end
        if (tx_if.tx_dv_o) begin
          dvq_byte.push_back(tx_if.tx_byte_o);
          dvq_idx.push_back(idx);
          dvq_cyc.push_back(cyc);
          tx_if.tx_active_i = 1'b1;
          fcnt = 10;
        end
        if (done) done_cnt++;
        if (abort) begin
          abort_cnt++;
          abort_cyc = cyc;
        end
      end
    end
  end

  task automatic pulse_start(output int c);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dvs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (dvq_byte.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fin(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt + abort_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (tx_if.tx_dv_o !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b want=0", tx_if.tx_dv_o); end
    checks++; if (tx_if.tx_byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h want=00", tx_if.tx_byte_o); end
    checks++; if (idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d want=0", idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b want=0", abort); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream;
    int base, d0, a0, sc;
    bit ok;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = byte_t'(k);
    unlock = 1'b1;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    repeat (3) @(negedge clk);
    key = '1;
    wait_fin(d0 + a0 + 1, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got=no_end want=end"); end
    repeat (2) @(negedge clk);
    checks++; if (dvq_byte.size() != base + NB) begin errors++; $display("FAIL stream_count got=%0d want=%0d", dvq_byte.size() - base, NB); end
    if (dvq_byte.size() == base + NB) begin
      checks++; if (dvq_cyc[base] - sc != 2) begin errors++; $display("FAIL first_dv_latency got=%0d want=2", dvq_cyc[base] - sc); end
      for (int k = 0; k < NB; k++) begin
        checks++; if (dvq_byte[base+k] !== byte_t'(k)) begin errors++; $display("FAIL stream_byte%0d got=%h want=%h", k, dvq_byte[base+k], byte_t'(k)); end
        checks++; if (dvq_idx[base+k] !== IW'(k)) begin errors++; $display("FAIL stream_idx%0d got=%0d want=%0d", k, dvq_idx[base+k], k); end
        if (k > 0) begin
          checks++; if (dvq_cyc[base+k] - dvq_cyc[base+k-1] != 15) begin errors++; $display("FAIL dv_spacing%0d got=%0d want=15", k, dvq_cyc[base+k] - dvq_cyc[base+k-1]); end
        end
      end
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL stream_done got=%0d want=1", done_cnt - d0); end
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL stream_abort got=%0d want=0", abort_cnt - a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy got=%b want=0", busy); end
    checks++; if (tx_if.tx_byte_o !== 8'h00) begin errors++; $display("FAIL idle_byte got=%h want=00", tx_if.tx_byte_o); end
    checks++; if (dut.shadow_q !== '0) begin errors++; $display("FAIL shadow_wipe got=nonzero want=0"); end
  endtask

  task automatic test_lock_loss;
    int base, d0, a0, sc;
    bit ok;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = byte_t'(8'h40 + k);
    unlock = 1'b1;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    wait_dvs(base + 6, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_dv6_timeout got=%0d want=6", dvq_byte.size() - base); end
    @(negedge clk);
    unlock = 1'b0;
    wait_fin(d0 + a0 + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lock_end_timeout got=no_end want=end"); end
    repeat (30) @(negedge clk);
    checks++; if (abort_cnt != a0 + 1) begin errors++; $display("FAIL lock_abort got=%0d want=1", abort_cnt - a0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL lock_done got=%0d want=0", done_cnt - d0); end
    checks++; if (dvq_byte.size() != base + 6) begin errors++; $display("FAIL lock_dv_count got=%0d want=6", dvq_byte.size() - base); end
    if (dvq_byte.size() >= base + 6) begin
      checks++; if (dvq_byte[base+5] !== 8'h45) begin errors++; $display("FAIL lock_byte5 got=%h want=45", dvq_byte[base+5]); end
      checks++; if (last_done_cyc != dvq_cyc[base+5] + 10) begin errors++; $display("FAIL lock_frame_done got=%0d want=%0d", last_done_cyc, dvq_cyc[base+5] + 10); end
    end
    checks++; if (abort_cyc != last_done_cyc + 1) begin errors++; $display("FAIL lock_abort_time got=%0d want=%0d", abort_cyc, last_done_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy got=%b want=0", busy); end
    unlock = 1'b1;
  endtask

  task automatic test_timeout;
    int base, d0, a0, sc;
    bit ok;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = byte_t'(8'hC0 + k);
    done_en = 1'b0;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    wait_fin(d0 + a0 + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_end_timeout got=no_abort want=abort"); end
    @(negedge clk);
    checks++; if (abort_cnt != a0 + 1) begin errors++; $display("FAIL to_abort got=%0d want=1", abort_cnt - a0); end
    checks++; if (dvq_byte.size() != base + 1) begin errors++; $display("FAIL to_dv_count got=%0d want=1", dvq_byte.size() - base); end
    if (dvq_byte.size() >= base + 1) begin
      checks++; if (abort_cyc - dvq_cyc[base] != 16) begin errors++; $display("FAIL to_latency got=%0d want=16", abort_cyc - dvq_cyc[base]); end
    end
    done_en = 1'b1;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    wait_fin(d0 + a0 + 1, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_restart_timeout got=no_end want=end"); end
    @(negedge clk);
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL to_restart_done got=%0d want=1", done_cnt - d0); end
    if (dvq_byte.size() >= base + 1) begin
      checks++; if (dvq_byte[base] !== 8'hC0) begin errors++; $display("FAIL to_restart_byte0 got=%h want=c0", dvq_byte[base]); end
    end
  endtask

  task automatic test_ignored_start;
    int base, d0, a0, sc;
    bit ok;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = byte_t'(8'h10 + k);
    unlock = 1'b0;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    repeat (20) @(negedge clk);
    checks++; if (dvq_byte.size() != base) begin errors++; $display("FAIL locked_start_dv got=%0d want=0", dvq_byte.size() - base); end
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL locked_start_abort got=%0d want=0", abort_cnt - a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL locked_start_busy got=%b want=0", busy); end
    unlock = 1'b1;
    pulse_start(sc);
    wait_dvs(base + 3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_dv3_timeout got=%0d want=3", dvq_byte.size() - base); end
    pulse_start(sc);
    wait_fin(d0 + a0 + 1, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_end_timeout got=no_end want=end"); end
    repeat (20) @(negedge clk);
    checks++; if (dvq_byte.size() != base + NB) begin errors++; $display("FAIL busy_start_count got=%0d want=%0d", dvq_byte.size() - base, NB); end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL busy_start_done got=%0d want=1", done_cnt - d0); end
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL busy_start_abort got=%0d want=0", abort_cnt - a0); end
    if (dvq_byte.size() == base + NB) begin
      checks++; if (dvq_byte[base+NB-1] !== 8'h2F) begin errors++; $display("FAIL busy_last_byte got=%h want=2f", dvq_byte[base+NB-1]); end
    end
  endtask

  task automatic test_reset_mid;
    int base, d0, a0, sc;
    bit ok;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = byte_t'(8'h80 + k);
    base = dvq_byte.size();
    pulse_start(sc);
    wait_dvs(base + 13, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_dv13_timeout got=%0d want=13", dvq_byte.size() - base); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_if.tx_byte_o !== 8'h00) begin errors++; $display("FAIL rst_mid_byte got=%h want=00", tx_if.tx_byte_o); end
    checks++; if (idx !== '0) begin errors++; $display("FAIL rst_mid_idx got=%0d want=0", idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; if (tx_if.tx_dv_o !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pulses got=%b%b%b want=000", tx_if.tx_dv_o, done, abort);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    wait_dvs(base + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_timeout got=no_dv want=dv"); end
    if (dvq_byte.size() >= base + 1) begin
      checks++; if (dvq_byte[base] !== 8'h80) begin errors++; $display("FAIL rst_restart_byte got=%h want=80", dvq_byte[base]); end
      checks++; if (dvq_idx[base] !== '0) begin errors++; $display("FAIL rst_restart_idx got=%0d want=0", dvq_idx[base]); end
    end
    wait_fin(d0 + a0 + 1, 1000, ok);
    checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL rst_restart_done got=%0d want=1", done_cnt - d0); end
    @(negedge clk);
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum(input byte_t b0, input byte_t rest, input byte_t want);
    int base, d0, a0, sc;
    bit ok;
    key = '0;
    for (int k = 0; k < NB; k++) key[k*8 +: 8] = (k == 0) ? b0 : rest;
    base = dvq_byte.size(); d0 = done_cnt; a0 = abort_cnt;
    pulse_start(sc);
    wait_fin(d0 + a0 + 1, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL csum_end_timeout got=no_end want=end"); end
    repeat (2) @(negedge clk);
    checks++; if (dvq_byte.size() != base + NB + 1) begin errors++; $display("FAIL csum_count got=%0d want=%0d", dvq_byte.size() - base, NB + 1); end
    if (dvq_byte.size() == base + NB + 1) begin
      checks++; if (dvq_byte[base+NB] !== want) begin errors++; $display("FAIL csum_byte got=%h want=%h", dvq_byte[base+NB], want); end
      checks++; if (dvq_idx[base+NB] !== IW'(NB)) begin errors++; $display("FAIL csum_idx got=%0d want=%0d", dvq_idx[base+NB], NB); end
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL csum_done got=%0d want=1", done_cnt - d0); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CHECKSUM_EN
    unlock = 1'b1;
    test_checksum(8'hA5, 8'hA5, 8'h00);
    test_checksum(8'h01, 8'h00, 8'h01);
`else
    test_stream();
    test_lock_loss();
    test_timeout();
    test_ignored_start();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
